// File: rtl/issue_pair_queue_if.sv
// Handshake bundle between fetch/issue (master) and the pair queue (slave).
// DEPTH is carried here only to size the occupancy count.
interface issue_pair_queue_if #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 13
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            fill_valid;
    logic [PC_W-1:0] fill_pc;
    logic [31:0]     fill_inst1;
    logic [31:0]     fill_inst2;
    logic            fill_ready;

    logic            issue_valid1;
    logic            issue_valid2;
    logic [PC_W-1:0] issue_pc1;
    logic [PC_W-1:0] issue_pc2;
    logic [31:0]     issue_inst1;
    logic [31:0]     issue_inst2;

    logic [1:0]      consume;
    logic            stall;
    logic            flush;
    logic [CW-1:0]   count;

    modport master (
        output fill_valid, fill_pc, fill_inst1, fill_inst2,
        output consume, stall, flush,
        input  fill_ready, issue_valid1, issue_valid2,
        input  issue_pc1, issue_pc2, issue_inst1, issue_inst2, count
    );

    modport slave (
        input  fill_valid, fill_pc, fill_inst1, fill_inst2,
        input  consume, stall, flush,
        output fill_ready, issue_valid1, issue_valid2,
        output issue_pc1, issue_pc2, issue_inst1, issue_inst2, count
    );
endinterface

// File: rtl/issue_pair_queue.sv
// Ring-buffer instruction queue: accepts fetched pairs, presents the two
// oldest entries to the dual-issue checker, retires 0/1/2 per cycle.
module issue_pair_queue #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 13
) (
    input  logic                 CLK,
    input  logic                 RST,
    issue_pair_queue_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] TWO_C   = CW'(2);

    logic [PC_W-1:0] pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr_p1;
    logic [AW-1:0] wr_ptr_p1;
    logic [CW-1:0] count_q;

    logic          fill_ready;
    logic          fill_take;
    logic [CW-1:0] cons_clip;
    logic [CW-1:0] take_n;
    logic [CW-1:0] count_nx;

    // Space check uses registered occupancy only, so a retire this cycle
    // never opens room for a fill in the same cycle.
    always_comb begin
        fill_ready = (DEPTH_C - count_q) >= TWO_C;
        fill_take  = bus.fill_valid & fill_ready & ~bus.flush;
        rd_ptr_p1  = rd_ptr + AW'(1);
        wr_ptr_p1  = wr_ptr + AW'(1);

        cons_clip = bus.consume[1] ? TWO_C : {{(CW-1){1'b0}}, bus.consume[0]};
        take_n    = '0;
        if (!bus.stall && !bus.flush) begin
            take_n = (cons_clip > count_q) ? count_q : cons_clip;
        end

        count_nx = count_q + (fill_take ? TWO_C : '0) - take_n;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            rd_ptr  <= rd_ptr + take_n[AW-1:0];
            if (fill_take) begin
                wr_ptr <= wr_ptr + AW'(2);
            end
            count_q <= count_nx;
        end
    end

    // Storage is deliberately unreset; pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (fill_take) begin
            pc_mem[wr_ptr]      <= bus.fill_pc;
            inst_mem[wr_ptr]    <= bus.fill_inst1;
            pc_mem[wr_ptr_p1]   <= bus.fill_pc + PC_W'(4);
            inst_mem[wr_ptr_p1] <= bus.fill_inst2;
        end
    end

    always_comb begin
        bus.fill_ready   = fill_ready;
        bus.count        = count_q;
        bus.issue_valid1 = count_q >= ONE_C;
        bus.issue_valid2 = count_q >= TWO_C;
        bus.issue_pc1    = '0;
        bus.issue_inst1  = '0;
        bus.issue_pc2    = '0;
        bus.issue_inst2  = '0;
        if (count_q >= ONE_C) begin
            bus.issue_pc1   = pc_mem[rd_ptr];
            bus.issue_inst1 = inst_mem[rd_ptr];
        end
        if (count_q >= TWO_C) begin
            bus.issue_pc2   = pc_mem[rd_ptr_p1];
            bus.issue_inst2 = inst_mem[rd_ptr_p1];
        end
    end
endmodule

// File: tb/tb_issue_pair_queue.sv
// Directed vector table plus hand sequences for reset-mid-fill and fill latency.
module tb_issue_pair_queue;
    localparam int DEPTH = 8;
    localparam int PC_W  = 13;
    localparam int NVEC  = 28;

    logic CLK;
    logic RST;
    int   checks;
    int   failures;

    issue_pair_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();

    issue_pair_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        fv;
        logic [12:0] pc;
        logic [31:0] i1;
        logic [31:0] i2;
        logic [1:0]  cons;
        logic        stall;
        logic        flush;
        logic [3:0]  ecount;
        logic        ev1;
        logic        ev2;
        logic        erdy;
        logic [12:0] epc1;
        logic [12:0] epc2;
        logic [31:0] ei1;
        logic [31:0] ei2;
    } vec_t;

    vec_t tbl [NVEC];

    function automatic vec_t mk(logic fv, logic [12:0] pc, logic [31:0] i1, logic [31:0] i2,
                                logic [1:0] cons, logic st, logic fl,
                                logic [3:0] ec, logic ev1, logic ev2, logic erdy,
                                logic [12:0] epc1, logic [12:0] epc2,
                                logic [31:0] ei1, logic [31:0] ei2);
        vec_t v;
        v.fv = fv; v.pc = pc; v.i1 = i1; v.i2 = i2;
        v.cons = cons; v.stall = st; v.flush = fl;
        v.ecount = ec; v.ev1 = ev1; v.ev2 = ev2; v.erdy = erdy;
        v.epc1 = epc1; v.epc2 = epc2; v.ei1 = ei1; v.ei2 = ei2;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic driveIdle();
        bus.fill_valid = 1'b0;
        bus.fill_pc    = '0;
        bus.fill_inst1 = '0;
        bus.fill_inst2 = '0;
        bus.consume    = 2'd0;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
    endtask

    task automatic checkState(input string tag, input logic [3:0] ec, input logic ev1, input logic ev2,
                              input logic erdy, input logic [12:0] epc1, input logic [12:0] epc2,
                              input logic [31:0] ei1, input logic [31:0] ei2);
        checkOutput({tag, ".count"},  32'(bus.count),        32'(ec));
        checkOutput({tag, ".valid1"}, 32'(bus.issue_valid1), 32'(ev1));
        checkOutput({tag, ".valid2"}, 32'(bus.issue_valid2), 32'(ev2));
        checkOutput({tag, ".ready"},  32'(bus.fill_ready),   32'(erdy));
        checkOutput({tag, ".pc1"},    32'(bus.issue_pc1),    32'(epc1));
        checkOutput({tag, ".pc2"},    32'(bus.issue_pc2),    32'(epc2));
        checkOutput({tag, ".inst1"},  bus.issue_inst1,       ei1);
        checkOutput({tag, ".inst2"},  bus.issue_inst2,       ei2);
    endtask

    // Drive one vector after the falling edge, then check one step past the rising edge.
    task automatic applyStimulus(input int idx);
        vec_t v;
        v = tbl[idx];
        @(negedge CLK);
        bus.fill_valid = v.fv;
        bus.fill_pc    = v.pc;
        bus.fill_inst1 = v.i1;
        bus.fill_inst2 = v.i2;
        bus.consume    = v.cons;
        bus.stall      = v.stall;
        bus.flush      = v.flush;
        @(posedge CLK);
        #1;
        checkState($sformatf("vec%0d", idx), v.ecount, v.ev1, v.ev2, v.erdy,
                   v.epc1, v.epc2, v.ei1, v.ei2);
    endtask

    localparam logic [31:0] IA  = 32'h0010_0093, IB  = 32'h0020_0113;
    localparam logic [31:0] P0A = 32'h1111_0000, P0B = 32'h1111_0001;
    localparam logic [31:0] P1A = 32'h1111_0002, P1B = 32'h1111_0003;
    localparam logic [31:0] P2A = 32'h1111_0004, P2B = 32'h1111_0005;
    localparam logic [31:0] P3A = 32'h1111_0006, P3B = 32'h1111_0007;
    localparam logic [31:0] DRA = 32'h0DEF_0000, DRB = 32'h0DEF_0001;
    localparam logic [31:0] IC  = 32'hCCCC_0000, ID  = 32'hDDDD_0000;
    localparam logic [31:0] E0  = 32'hEEEE_0000, E1  = 32'hEEEE_0001;
    localparam logic [31:0] F0  = 32'hFFFF_0000, F1  = 32'hFFFF_0001;
    localparam logic [31:0] G0  = 32'h6666_0000, G1  = 32'h6666_0001;
    localparam logic [31:0] H0  = 32'h1234_0000, H1  = 32'h1234_0001;
    localparam logic [31:0] H2  = 32'h1234_0002, H3  = 32'h1234_0003;
    localparam logic [31:0] BD0 = 32'h0BAD_0000, BD1 = 32'h0BAD_0001;
    localparam logic [31:0] K0  = 32'hABCD_0000, K1  = 32'hABCD_0001;

    initial begin
        checks   = 0;
        failures = 0;

        //             fv  pc       i1   i2   cons st fl | cnt v1 v2 rdy pc1      pc2      inst1 inst2
        tbl[0]  = mk(1, 13'h010, IA,  IB,  2'd0, 0, 0, 4'd2, 1, 1, 1, 13'h010, 13'h014, IA,  IB);
        tbl[1]  = mk(0, 13'h000, 0,   0,   2'd1, 0, 0, 4'd1, 1, 0, 1, 13'h014, 13'h000, IB,  0);
        tbl[2]  = mk(0, 13'h000, 0,   0,   2'd1, 0, 0, 4'd0, 0, 0, 1, 13'h000, 13'h000, 0,   0);
        tbl[3]  = mk(1, 13'h100, P0A, P0B, 2'd0, 0, 0, 4'd2, 1, 1, 1, 13'h100, 13'h104, P0A, P0B);
        tbl[4]  = mk(1, 13'h108, P1A, P1B, 2'd0, 0, 0, 4'd4, 1, 1, 1, 13'h100, 13'h104, P0A, P0B);
        tbl[5]  = mk(1, 13'h110, P2A, P2B, 2'd0, 0, 0, 4'd6, 1, 1, 1, 13'h100, 13'h104, P0A, P0B);
        tbl[6]  = mk(1, 13'h118, P3A, P3B, 2'd0, 0, 0, 4'd8, 1, 1, 0, 13'h100, 13'h104, P0A, P0B);
        tbl[7]  = mk(1, 13'h200, DRA, DRB, 2'd0, 0, 0, 4'd8, 1, 1, 0, 13'h100, 13'h104, P0A, P0B);
        tbl[8]  = mk(1, 13'h200, DRA, DRB, 2'd2, 0, 0, 4'd6, 1, 1, 1, 13'h108, 13'h10C, P1A, P1B);
        tbl[9]  = mk(0, 13'h000, 0,   0,   2'd2, 1, 0, 4'd6, 1, 1, 1, 13'h108, 13'h10C, P1A, P1B);
        tbl[10] = mk(0, 13'h000, 0,   0,   2'd3, 0, 0, 4'd4, 1, 1, 1, 13'h110, 13'h114, P2A, P2B);
        tbl[11] = mk(1, 13'h1FFC, IC, ID,  2'd2, 0, 0, 4'd4, 1, 1, 1, 13'h118, 13'h11C, P3A, P3B);
        tbl[12] = mk(0, 13'h000, 0,   0,   2'd2, 0, 0, 4'd2, 1, 1, 1, 13'h1FFC, 13'h000, IC, ID);
        tbl[13] = mk(0, 13'h000, 0,   0,   2'd1, 0, 0, 4'd1, 1, 0, 1, 13'h000, 13'h000, ID,  0);
        tbl[14] = mk(1, 13'h300, E0,  E1,  2'd0, 0, 0, 4'd3, 1, 1, 1, 13'h000, 13'h300, ID,  E0);
        tbl[15] = mk(0, 13'h000, 0,   0,   2'd2, 0, 0, 4'd1, 1, 0, 1, 13'h304, 13'h000, E1,  0);
        tbl[16] = mk(1, 13'h400, F0,  F1,  2'd0, 0, 0, 4'd3, 1, 1, 1, 13'h304, 13'h400, E1,  F0);
        tbl[17] = mk(1, 13'h500, G0,  G1,  2'd0, 0, 0, 4'd5, 1, 1, 1, 13'h304, 13'h400, E1,  F0);
        tbl[18] = mk(0, 13'h000, 0,   0,   2'd2, 0, 0, 4'd3, 1, 1, 1, 13'h404, 13'h500, F1,  G0);
        tbl[19] = mk(0, 13'h000, 0,   0,   2'd1, 0, 0, 4'd2, 1, 1, 1, 13'h500, 13'h504, G0,  G1);
        tbl[20] = mk(0, 13'h000, 0,   0,   2'd2, 1, 0, 4'd2, 1, 1, 1, 13'h500, 13'h504, G0,  G1);
        tbl[21] = mk(0, 13'h000, 0,   0,   2'd1, 0, 0, 4'd1, 1, 0, 1, 13'h504, 13'h000, G1,  0);
        tbl[22] = mk(0, 13'h000, 0,   0,   2'd3, 0, 0, 4'd0, 0, 0, 1, 13'h000, 13'h000, 0,   0);
        tbl[23] = mk(0, 13'h000, 0,   0,   2'd2, 0, 0, 4'd0, 0, 0, 1, 13'h000, 13'h000, 0,   0);
        tbl[24] = mk(1, 13'h600, H0,  H1,  2'd0, 0, 0, 4'd2, 1, 1, 1, 13'h600, 13'h604, H0,  H1);
        tbl[25] = mk(1, 13'h608, H2,  H3,  2'd0, 0, 0, 4'd4, 1, 1, 1, 13'h600, 13'h604, H0,  H1);
        tbl[26] = mk(1, 13'h700, BD0, BD1, 2'd2, 0, 1, 4'd0, 0, 0, 1, 13'h000, 13'h000, 0,   0);
        tbl[27] = mk(1, 13'h800, K0,  K1,  2'd0, 0, 0, 4'd2, 1, 1, 1, 13'h800, 13'h804, K0,  K1);

        driveIdle();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checkState("reset", 4'd0, 0, 0, 1, 13'h000, 13'h000, 0, 0);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(i);
        end

        // Reset asserted mid-cycle during a fill must clear outputs without a clock edge.
        @(negedge CLK);
        bus.fill_valid = 1'b1;
        bus.fill_pc    = 13'h900;
        bus.fill_inst1 = 32'h9999_0000;
        bus.fill_inst2 = 32'h9999_0001;
        #2;
        RST = 1'b1;
        #1;
        checkState("rst_async", 4'd0, 0, 0, 1, 13'h000, 13'h000, 0, 0);
        @(posedge CLK);
        #1;
        checkState("rst_held", 4'd0, 0, 0, 1, 13'h000, 13'h000, 0, 0);
        @(negedge CLK);
        driveIdle();
        RST = 1'b0;
        @(posedge CLK);
        #1;
        checkState("rst_idle", 4'd0, 0, 0, 1, 13'h000, 13'h000, 0, 0);

        // Accepted fill is not visible before the edge, and is visible right after it.
        @(negedge CLK);
        bus.fill_valid = 1'b1;
        bus.fill_pc    = 13'h010;
        bus.fill_inst1 = IA;
        bus.fill_inst2 = IB;
        #1;
        checkOutput("lat.pre_count",  32'(bus.count),        32'd0);
        checkOutput("lat.pre_valid1", 32'(bus.issue_valid1), 32'd0);
        @(posedge CLK);
        #1;
        checkState("lat.post", 4'd2, 1, 1, 1, 13'h010, 13'h014, IA, IB);
        @(negedge CLK);
        driveIdle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
